// File: rtl/regfile_scoreboard.sv
// Multi-port register file with write-to-read bypass and a per-register
// pending bit. Issue logic reserves a destination ahead of its write-back and
// can stall on A_BUSY/B_BUSY. BUSY_CNT keeps a running count of pending
// registers. RSV_ERR flags a reservation of a register that is already pending.
module regfile_scoreboard #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned ADDR_W   = 4,
    parameter bit          ZERO_REG = 1'b0,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic              C,
    input  logic              RST_N,
    input  logic [WIDTH-1:0]  D,
    input  logic [ADDR_W-1:0] DEST_SEL,
    input  logic              LOAD_EN,
    input  logic [ADDR_W-1:0] A_SEL,
    input  logic [ADDR_W-1:0] B_SEL,
    output logic [WIDTH-1:0]  A,
    output logic [WIDTH-1:0]  B,
    output logic              A_BUSY,
    output logic              B_BUSY,
    input  logic              RSV_EN,
    input  logic [ADDR_W-1:0] RSV_SEL,
    output logic              RSV_BUSY,
    output logic              RSV_ERR,
    output logic [ADDR_W:0]   BUSY_CNT
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CntW  = ADDR_W + 1;

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0] pend_q, pend_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             err_q, err_d;

    // Register 0 is inert when hardwired to zero: no writes, reservations or bypass.
    logic dest_is_zero, rsv_is_zero;
    logic wr_en, rs_en;
    logic same_reg;
    logic cnt_inc, cnt_dec;

    assign dest_is_zero = ZERO_REG && (DEST_SEL == '0);
    assign rsv_is_zero  = ZERO_REG && (RSV_SEL == '0);
    assign wr_en        = LOAD_EN && !dest_is_zero;
    assign rs_en        = RSV_EN && !rsv_is_zero;
    assign same_reg     = (DEST_SEL == RSV_SEL);

    // Read port A: zero register, then same-cycle bypass, then storage.
    logic a_hit;
    always_comb begin
        a_hit  = BYPASS && LOAD_EN && (DEST_SEL == A_SEL);
        A      = regs_q[A_SEL];
        A_BUSY = pend_q[A_SEL];
        if (ZERO_REG && (A_SEL == '0)) begin
            A      = '0;
            A_BUSY = 1'b0;
        end else if (a_hit) begin
            // The in-flight write resolves the hazard this cycle.
            A      = D;
            A_BUSY = 1'b0;
        end
    end

    // Read port B: same priority as port A.
    logic b_hit;
    always_comb begin
        b_hit  = BYPASS && LOAD_EN && (DEST_SEL == B_SEL);
        B      = regs_q[B_SEL];
        B_BUSY = pend_q[B_SEL];
        if (ZERO_REG && (B_SEL == '0)) begin
            B      = '0;
            B_BUSY = 1'b0;
        end else if (b_hit) begin
            B      = D;
            B_BUSY = 1'b0;
        end
    end

    // Reservation probe: raw pending bit, deliberately not masked by a same-cycle write.
    always_comb begin
        RSV_BUSY = pend_q[RSV_SEL];
        if (rsv_is_zero) begin
            RSV_BUSY = 1'b0;
        end
    end

    // Next-state for storage and pending bits; a reserve overrides a release of the same register.
    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        if (wr_en) begin
            regs_d[DEST_SEL] = D;
            pend_d[DEST_SEL] = 1'b0;
        end
        if (rs_en) begin
            pend_d[RSV_SEL] = 1'b1;
        end
    end

    // Incremental count and double-reservation detect derived from the same transitions.
    always_comb begin
        // A fresh reservation only counts if the bit was clear before the edge.
        cnt_inc = rs_en && !pend_q[RSV_SEL];
        // A release only counts if the bit was set and no reserve re-takes it.
        cnt_dec = wr_en && pend_q[DEST_SEL] && !(rs_en && same_reg);
        cnt_d   = cnt_q + CntW'(cnt_inc) - CntW'(cnt_dec);
        // Write+reserve to the same register is a hand-over, not a double reservation.
        err_d   = rs_en && pend_q[RSV_SEL] && !(wr_en && same_reg);
    end

    // Storage array, cleared by reset.
    always_ff @(posedge C or negedge RST_N) begin
        if (!RST_N) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Scoreboard state: pending vector, pending count and error pulse.
    always_ff @(posedge C or negedge RST_N) begin
        if (!RST_N) begin
            pend_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign RSV_ERR  = err_q;
    assign BUSY_CNT = cnt_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard. Two instances share stimulus:
// dut0 uses ZERO_REG=0/BYPASS=1, dut1 uses ZERO_REG=1/BYPASS=0. A driver
// pushes predicted outputs from a reference model; a monitor pops and compares.
module tb_regfile_scoreboard;

    logic        C = 1'b0;
    logic        RST_N = 1'b1;
    logic [15:0] D = '0;
    logic [3:0]  DEST_SEL = '0;
    logic        LOAD_EN = 1'b0;
    logic [3:0]  A_SEL = '0;
    logic [3:0]  B_SEL = '0;
    logic        RSV_EN = 1'b0;
    logic [3:0]  RSV_SEL = '0;

    logic [15:0] a0, b0, a1, b1;
    logic        ab0, bb0, rb0, err0, ab1, bb1, rb1, err1;
    logic [4:0]  cnt0, cnt1;

    always #5 C = ~C;

    regfile_scoreboard #(.WIDTH(16), .ADDR_W(4), .ZERO_REG(1'b0), .BYPASS(1'b1)) dut0 (
        .C(C), .RST_N(RST_N), .D(D), .DEST_SEL(DEST_SEL), .LOAD_EN(LOAD_EN),
        .A_SEL(A_SEL), .B_SEL(B_SEL), .A(a0), .B(b0), .A_BUSY(ab0), .B_BUSY(bb0),
        .RSV_EN(RSV_EN), .RSV_SEL(RSV_SEL), .RSV_BUSY(rb0), .RSV_ERR(err0),
        .BUSY_CNT(cnt0)
    );

    regfile_scoreboard #(.WIDTH(16), .ADDR_W(4), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut1 (
        .C(C), .RST_N(RST_N), .D(D), .DEST_SEL(DEST_SEL), .LOAD_EN(LOAD_EN),
        .A_SEL(A_SEL), .B_SEL(B_SEL), .A(a1), .B(b1), .A_BUSY(ab1), .B_BUSY(bb1),
        .RSV_EN(RSV_EN), .RSV_SEL(RSV_SEL), .RSV_BUSY(rb1), .RSV_ERR(err1),
        .BUSY_CNT(cnt1)
    );

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        ab;
        logic        bb;
        logic        rb;
        logic        err;
        logic [4:0]  cnt;
    } obs_t;

    obs_t q0[$];
    obs_t q1[$];
    int   n_checks = 0;
    int   n_pass = 0;

    // Reference model, one copy per configuration (0: dut0, 1: dut1).
    logic [15:0] mreg  [2][16];
    bit          mpend [2][16];
    bit          merr  [2];

    function automatic obs_t predict(input int c);
        obs_t o;
        bit   zr  = (c == 1);
        bit   byp = (c == 0);
        int   pc  = 0;
        if (zr && A_SEL == 4'd0) begin
            o.a = '0; o.ab = 1'b0;
        end else if (byp && LOAD_EN && DEST_SEL == A_SEL) begin
            o.a = D; o.ab = 1'b0;
        end else begin
            o.a = mreg[c][A_SEL]; o.ab = mpend[c][A_SEL];
        end
        if (zr && B_SEL == 4'd0) begin
            o.b = '0; o.bb = 1'b0;
        end else if (byp && LOAD_EN && DEST_SEL == B_SEL) begin
            o.b = D; o.bb = 1'b0;
        end else begin
            o.b = mreg[c][B_SEL]; o.bb = mpend[c][B_SEL];
        end
        o.rb  = mpend[c][RSV_SEL];
        o.err = merr[c];
        for (int i = 0; i < 16; i++) pc += int'(mpend[c][i]);
        o.cnt = 5'(pc);
        return o;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 16; i++) begin
                mreg[c][i]  = '0;
                mpend[c][i] = 1'b0;
            end
            merr[c] = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int c = 0; c < 2; c++) begin
            bit zr   = (c == 1);
            bit w_ok = LOAD_EN && !(zr && DEST_SEL == 4'd0);
            bit r_ok = RSV_EN && !(zr && RSV_SEL == 4'd0);
            merr[c] = r_ok && mpend[c][RSV_SEL] && !(w_ok && DEST_SEL == RSV_SEL);
            if (w_ok) begin
                mreg[c][DEST_SEL]  = D;
                mpend[c][DEST_SEL] = 1'b0;
            end
            if (r_ok) mpend[c][RSV_SEL] = 1'b1;
        end
    endtask

    // One cycle of stimulus: drive between edges, log expectations, advance the model.
    task automatic drive(input bit rst, input bit le, input logic [3:0] dest,
                         input logic [15:0] d, input logic [3:0] as, input logic [3:0] bs,
                         input bit re, input logic [3:0] rs);
        @(negedge C);
        RST_N = rst; LOAD_EN = le; DEST_SEL = dest; D = d;
        A_SEL = as; B_SEL = bs; RSV_EN = re; RSV_SEL = rs;
        if (!rst) model_reset();
        q0.push_back(predict(0));
        q1.push_back(predict(1));
        if (rst) model_edge();
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Monitor: compare every cycle for which an expectation is queued.
    initial begin
        obs_t e;
        forever begin
            @(negedge C);
            #2;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                chk("d0.A", a0, e.a);          chk("d0.B", b0, e.b);
                chk("d0.A_BUSY", 16'(ab0), 16'(e.ab));
                chk("d0.B_BUSY", 16'(bb0), 16'(e.bb));
                chk("d0.RSV_BUSY", 16'(rb0), 16'(e.rb));
                chk("d0.RSV_ERR", 16'(err0), 16'(e.err));
                chk("d0.BUSY_CNT", 16'(cnt0), 16'(e.cnt));
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("d1.A", a1, e.a);          chk("d1.B", b1, e.b);
                chk("d1.A_BUSY", 16'(ab1), 16'(e.ab));
                chk("d1.B_BUSY", 16'(bb1), 16'(e.bb));
                chk("d1.RSV_BUSY", 16'(rb1), 16'(e.rb));
                chk("d1.RSV_ERR", 16'(err1), 16'(e.err));
                chk("d1.BUSY_CNT", 16'(cnt1), 16'(e.cnt));
            end
        end
    end

    initial begin
        logic [3:0]  r_dest, r_as, r_bs, r_rs;
        logic [15:0] r_d;
        bit          r_le, r_re, r_rst;
        model_reset();
        #1 RST_N = 1'b0;
        drive(0, 0, 4'd0, 16'h0, 4'd0, 4'd0, 0, 4'd0);
        // Every register reads zero after reset.
        for (int i = 0; i < 16; i++) drive(1, 0, 4'd0, 16'h0, 4'(i), 4'(15 - i), 0, 4'd0);
        // Write with bypass on both ports, then the registered value.
        drive(1, 1, 4'd3, 16'hA5A5, 4'd3, 4'd3, 0, 4'd0);
        drive(1, 0, 4'd0, 16'h0, 4'd3, 4'd3, 0, 4'd0);
        // Reserve then release r5.
        drive(1, 0, 4'd0, 16'h0, 4'd5, 4'd5, 1, 4'd5);
        drive(1, 1, 4'd5, 16'h1234, 4'd5, 4'd5, 0, 4'd5);
        drive(1, 0, 4'd0, 16'h0, 4'd5, 4'd3, 0, 4'd5);
        // Double reservation of r7, then write+reserve hand-over.
        drive(1, 0, 4'd0, 16'h0, 4'd7, 4'd7, 1, 4'd7);
        drive(1, 0, 4'd0, 16'h0, 4'd7, 4'd7, 1, 4'd7);
        drive(1, 0, 4'd0, 16'h0, 4'd7, 4'd7, 0, 4'd7);
        drive(1, 0, 4'd0, 16'h0, 4'd7, 4'd7, 0, 4'd7);
        drive(1, 1, 4'd7, 16'h7777, 4'd7, 4'd7, 1, 4'd7);
        drive(1, 0, 4'd0, 16'h0, 4'd7, 4'd7, 0, 4'd7);
        // Register 0: write and reserve together.
        drive(1, 1, 4'd0, 16'hFFFF, 4'd0, 4'd0, 1, 4'd0);
        drive(1, 0, 4'd1, 16'h0, 4'd0, 4'd0, 0, 4'd0);
        drive(1, 0, 4'd1, 16'h0, 4'd0, 4'd0, 1, 4'd0);
        // Fill the scoreboard.
        for (int i = 0; i < 16; i++) drive(1, 0, 4'd0, 16'h0, 4'(i), 4'd9, 1, 4'(i));
        drive(1, 0, 4'd0, 16'h0, 4'd3, 4'd9, 0, 4'd2);
        // Reset between edges; edges under reset must not write or reserve.
        drive(0, 1, 4'd2, 16'hBEEF, 4'd2, 4'd3, 0, 4'd5);
        drive(0, 1, 4'd6, 16'hCAFE, 4'd4, 4'd6, 1, 4'd4);
        drive(1, 0, 4'd0, 16'h0, 4'd4, 4'd6, 0, 4'd2);
        drive(1, 0, 4'd0, 16'h0, 4'd3, 4'd5, 0, 4'd4);
        // Randomized traffic, biased toward a few registers to provoke collisions.
        for (int n = 0; n < 600; n++) begin
            r_rst  = ($urandom_range(0, 99) != 0);
            r_le   = ($urandom_range(0, 2) == 0);
            r_re   = ($urandom_range(0, 2) == 0);
            r_d    = 16'($urandom);
            r_dest = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            r_rs   = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            r_as   = ($urandom_range(0, 2) == 0) ? r_dest : 4'($urandom_range(0, 15));
            r_bs   = ($urandom_range(0, 2) == 0) ? r_rs : 4'($urandom_range(0, 3));
            drive(r_rst, r_le, r_dest, r_d, r_as, r_bs, r_re, r_rs);
        end
        drive(1, 0, 4'd0, 16'h0, 4'd0, 4'd1, 0, 4'd0);
        @(negedge C);
        #5;
        n_checks++;
        if (q0.size() == 0 && q1.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d/%0d queued expected 0/0", q0.size(), q1.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
